rr_mux_arb: RTL and testbench

- Parametrised successor to the team's 2:1 mux: NCH-input, WIDTH-bit registered multiplexer with per-channel valid/ready handshake and built-in arbitration.
- Selection is no longer a free-running select input. An internal arbiter picks one requesting channel per transfer, in round-robin or fixed-priority mode.
- Output is registered with one-cycle latency. The block sits between several producers and a single shared consumer.

---
 rtl/rr_mux_arb_pkg.sv | 19 +
 rtl/rr_mux_arb_pick.sv | 54 +++++
 rtl/rr_mux_arb.sv | 108 ++++++++++
 tb/tb_rr_mux_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arb_pkg.sv
// Shared definitions for the arbitrated multiplexer: default sizing,
// arbitration mode encoding and the wrapping pointer increment.
package rr_mux_arb_pkg;

    localparam int unsigned NCH_DEFAULT   = 4;
    localparam int unsigned WIDTH_DEFAULT = 8;

    // Value carried on rr_en
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Advance a channel index, wrapping at n-1 rather than at a power of two
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_mux_arb_pick.sv
// Combinational rotate-priority picker.
// Ports:
//   req     - per-channel request vector
//   ptr     - highest-priority channel when rr_en=1
//   rr_en   - 1: search from ptr with wrap-around, 0: lowest index wins
//   gnt     - one-hot grant (zero when no request)
//   gnt_idx - index of the granted channel (0 when no request)
//   any     - at least one request is present
module rr_pick
    import rr_mux_arb_pkg::*;
#(
    parameter  int unsigned NCH  = NCH_DEFAULT,
    localparam int unsigned SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic            rr_en,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic [SELW-1:0] ptr_eff_c;
    logic [NCH-1:0]  hi_mask_c;
    logic [NCH-1:0]  req_hi_c;
    logic [NCH-1:0]  pick_vec_c;

    // Requests at or above the pointer win; if none, wrap to the lowest request.
    // Fixed priority is the same search with the pointer forced to zero.
    always_comb begin
        ptr_eff_c = '0;
        if ((arb_mode_e'(rr_en) == ARB_RR) && (32'(ptr) < NCH)) begin
            ptr_eff_c = ptr;
        end
        for (int i = 0; i < NCH; i++) begin
            hi_mask_c[i] = (32'(i) >= 32'(ptr_eff_c));
        end
        req_hi_c   = req & hi_mask_c;
        pick_vec_c = (|req_hi_c) ? req_hi_c : req;
    end

    // Lowest set bit of the chosen vector
    always_comb begin
        gnt_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pick_vec_c[i]) begin
                gnt_idx = SELW'(i);
            end
        end
        any = |req;
        gnt = any ? (NCH'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/rr_mux_arb.sv
// NCH-input registered multiplexer with per-channel valid/ready and a
// built-in round-robin / fixed-priority arbiter. One word per clock
// throughput, one clock from input transfer to out_valid.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   rr_en      - 1: round-robin, 0: fixed priority (lowest index wins)
//   in_valid   - per-channel valid
//   in_data    - packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   - per-channel accept, one-hot or zero
//   out_valid  - output register holds a word
//   out_data   - registered selected data
//   out_sel    - channel that supplied out_data
//   out_ready  - consumer accepts out_data
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter  int unsigned NCH   = NCH_DEFAULT,
    parameter  int unsigned WIDTH = WIDTH_DEFAULT,
    localparam int unsigned SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rr_en,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic [NCH-1:0]   gnt_c;
    logic [SELW-1:0]  gnt_idx_c;
    logic             any_c;
    logic             can_load_c;
    logic             load_c;
    logic [WIDTH-1:0] gnt_data_c;

    rr_pick #(
        .NCH (NCH)
    ) u_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .rr_en   (rr_en),
        .gnt     (gnt_c),
        .gnt_idx (gnt_idx_c),
        .any     (any_c)
    );

    // Output stage is empty or draining; reset also blocks acceptance
    always_comb begin
        can_load_c = (!out_valid_q || out_ready) && rst_n;
        load_c     = any_c && can_load_c;
        in_ready   = can_load_c ? gnt_c : '0;
    end

    // One-hot AND-OR data select, so non-granted data cannot leak through
    always_comb begin
        gnt_data_c = '0;
        for (int i = 0; i < NCH; i++) begin
            gnt_data_c = gnt_data_c | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt_c[i]}});
        end
    end

    // Next state of output register and priority pointer
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load_c) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data_c;
            out_sel_d   = gnt_idx_c;
            if (arb_mode_e'(rr_en) == ARB_RR) begin
                ptr_d = SELW'(wrap_inc(32'(gnt_idx_c), NCH));
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Scoreboard bench for rr_mux_arb: a 4-channel and a 3-channel instance
// run side by side against a rotation-order reference model.
module tb_rr_mux_arb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: NCH=4, instance 1: NCH=3
    logic       rr0, or0, ov0;
    logic [3:0] iv0, ir0;
    logic [31:0] id0;
    logic [7:0] od0;
    logic [1:0] os0;
    logic       rr1, or1, ov1;
    logic [2:0] iv1, ir1;
    logic [23:0] id1;
    logic [7:0] od1;
    logic [1:0] os1;

    // Applied stimulus (changed only just after a falling edge)
    logic [3:0] s_iv[2];
    logic [7:0] s_dat[2][4];
    logic       s_rr[2];
    logic       s_ordy[2];
    // Staged values copied into the applied stimulus by drive()
    logic [7:0] st_dat[2][4];
    logic       st_rr[2];

    assign iv0 = s_iv[0];
    assign id0 = {s_dat[0][3], s_dat[0][2], s_dat[0][1], s_dat[0][0]};
    assign rr0 = s_rr[0];
    assign or0 = s_ordy[0];
    assign iv1 = s_iv[1][2:0];
    assign id1 = {s_dat[1][2], s_dat[1][1], s_dat[1][0]};
    assign rr1 = s_rr[1];
    assign or1 = s_ordy[1];

    rr_mux_arb #(.NCH(4), .WIDTH(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rr_en(rr0), .in_valid(iv0), .in_data(id0),
        .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(or0)
    );

    rr_mux_arb #(.NCH(3), .WIDTH(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rr_en(rr1), .in_valid(iv1), .in_data(id1),
        .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(or1)
    );

    int n_chk;
    int n_err;
    bit mon_en;

    // Reference model state
    int m_ptr[2];
    bit m_ov[2];
    bit consumed[2];
    int q0[$];
    int q1[$];

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic [3:0] get_ir(input int d);
        return (d == 0) ? ir0 : {1'b0, ir1};
    endfunction
    function automatic logic get_ov(input int d);
        return (d == 0) ? ov0 : ov1;
    endfunction
    function automatic logic [7:0] get_od(input int d);
        return (d == 0) ? od0 : od1;
    endfunction
    function automatic logic [1:0] get_os(input int d);
        return (d == 0) ? os0 : os1;
    endfunction

    function automatic void qpush(input int d, input int e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endfunction
    function automatic void qpop(input int d);
        if (d == 0) begin if (q0.size() > 0) void'(q0.pop_front()); end
        else begin if (q1.size() > 0) void'(q1.pop_front()); end
    endfunction
    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction
    function automatic int qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    // First requesting channel in the order base, base+1, ..., wrapping modulo n
    function automatic int pick(input logic [3:0] v, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (base + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Check in_ready for the current inputs and record what the output must become
    task automatic predict();
        #1;
        for (int d = 0; d < 2; d++) begin
            int         n;
            int         g;
            bit         can_load;
            logic [3:0] v;
            logic [3:0] exp_ir;
            n        = nch(d);
            v        = s_iv[d] & 4'((1 << n) - 1);
            can_load = !m_ov[d] || s_ordy[d];
            g        = pick(v, s_rr[d] ? m_ptr[d] : 0, n);
            exp_ir   = (g >= 0 && can_load) ? 4'(1 << g) : 4'b0;
            chk("in_ready", d, 32'(get_ir(d)), 32'(exp_ir));
            consumed[d] = m_ov[d] && s_ordy[d];
            if (exp_ir != 4'b0) begin
                qpush(d, g * 256 + int'(s_dat[d][g]));
                if (s_rr[d]) m_ptr[d] = (g + 1) % n;
                m_ov[d] = 1'b1;
            end else if (s_ordy[d]) begin
                m_ov[d] = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic [3:0] v0, input logic [3:0] v1, input bit r0, input bit r1);
        @(negedge clk);
        s_iv[0]   = v0;
        s_iv[1]   = v1 & 4'b0111;
        s_ordy[0] = r0;
        s_ordy[1] = r1;
        for (int d = 0; d < 2; d++) begin
            s_rr[d] = st_rr[d];
            for (int i = 0; i < 4; i++) s_dat[d][i] = st_dat[d][i];
        end
        predict();
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]    = 0;
            m_ov[d]     = 1'b0;
            consumed[d] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", d, 32'(get_ov(d)), 32'd0);
            chk("rst_out_data",  d, 32'(get_od(d)), 32'd0);
            chk("rst_out_sel",   d, 32'(get_os(d)), 32'd0);
            chk("rst_in_ready",  d, 32'(get_ir(d)), 32'd0);
        end
    endtask

    // Monitor: after each rising edge, retire consumed words and compare the held word
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && mon_en) begin
                for (int d = 0; d < 2; d++) begin
                    bit exp_v;
                    int e;
                    if (consumed[d]) qpop(d);
                    exp_v = (qsize(d) > 0);
                    chk("out_valid", d, 32'(get_ov(d)), 32'(exp_v));
                    if (exp_v && get_ov(d)) begin
                        e = qfront(d);
                        chk("out_data", d, 32'(get_od(d)), 32'(e % 256));
                        chk("out_sel",  d, 32'(get_os(d)), 32'(e / 256));
                    end
                    if (d == 1 && ov1) chk("sel_range", d, 32'(os1 == 2'd3), 32'd0);
                end
            end
        end
    end

    initial begin
        n_chk  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_iv[d]   = 4'hF;
            s_rr[d]   = 1'b1;
            st_rr[d]  = 1'b1;
            s_ordy[d] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                s_dat[d][i]  = 8'h00;
                st_dat[d][i] = 8'h00;
            end
        end
        model_reset();
        rst_n = 1'b0;

        // Reset holds everything at zero even with requests pending
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n   = 1'b1;
        s_iv[0] = 4'h0;
        s_iv[1] = 4'h0;
        mon_en  = 1'b1;
        predict();
        repeat (2) drive(4'h0, 4'h0, 1'b1, 1'b1);

        // Single requester
        st_dat[0][2] = 8'hA5;
        drive(4'b0100, 4'h0, 1'b1, 1'b1);
        repeat (2) drive(4'h0, 4'h0, 1'b1, 1'b1);

        // Round-robin with all channels requesting
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) st_dat[d][i] = 8'(8'h10 + i);
        repeat (12) drive(4'hF, 4'h7, 1'b1, 1'b1);

        // Fixed priority
        st_rr[0] = 1'b0;
        st_rr[1] = 1'b0;
        repeat (6) drive(4'b1010, 4'b0110, 1'b1, 1'b1);
        st_rr[0] = 1'b1;
        st_rr[1] = 1'b1;
        drive(4'h0, 4'h0, 1'b1, 1'b1);

        // Backpressure: hold 0x33 for 5 stalled cycles, then reload without a bubble
        st_dat[0][0] = 8'h33;
        drive(4'b0001, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) st_dat[0][i] = 8'(8'h40 + i);
        repeat (5) drive(4'hF, 4'h0, 1'b0, 1'b1);
        drive(4'hF, 4'h0, 1'b1, 1'b1);
        repeat (2) drive(4'h0, 4'h0, 1'b1, 1'b1);

        // Three channels: pointer reaches 2, then {ch1,ch0} must grant ch0
        for (int i = 0; i < 4; i++) st_dat[1][i] = 8'(8'h60 + i);
        drive(4'h0, 4'b0010, 1'b1, 1'b1);
        drive(4'h0, 4'b0011, 1'b1, 1'b1);
        repeat (4) drive(4'h0, 4'b0111, 1'b1, 1'b1);
        repeat (2) drive(4'h0, 4'h0, 1'b1, 1'b1);

        // Random traffic, mode toggles and backpressure
        repeat (600) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 4; i++) st_dat[d][i] = 8'($urandom);
                if ($urandom_range(15) == 0) st_rr[d] = ~st_rr[d];
            end
            drive(4'($urandom), 4'($urandom_range(7)),
                  $urandom_range(3) != 0, $urandom_range(3) != 0);
        end

        // Reset in the middle of a stall discards the held word and the pointer
        st_rr[0] = 1'b1;
        st_rr[1] = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) st_dat[d][i] = 8'(8'h5A + i);
        drive(4'hF, 4'h7, 1'b1, 1'b1);
        repeat (2) drive(4'hF, 4'h7, 1'b0, 1'b0);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        s_iv[0] = 4'h0;
        s_iv[1] = 4'h0;
        predict();
        repeat (2) drive(4'h0, 4'h0, 1'b1, 1'b1);
        repeat (6) drive(4'hF, 4'h7, 1'b1, 1'b1);
        repeat (2) drive(4'h0, 4'h0, 1'b1, 1'b1);

        mon_en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
